cam_frame_buffer: RTL

Camera-side frame store sitting directly behind the CPU memory mux's camera port. It takes a raw 8-bit grayscale pixel stream, decimates it on the fly to a 28×28 MNIST-sized image, and holds it in an internal 784-byte buffer. The CPU then drains the buffer one pixel per read strobe. A capture strobe from the mux arms one frame grab; the read strobe pops the current pixel, which is presented show-ahead on `pixel_o`.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_pixel_ram.sv | 36 +++
 rtl/cam_frame_buffer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared constants, state encoding and decimation helper for the camera frame buffer.
package cam_pkg;

    localparam int SRC_W = 224;
    localparam int SRC_H = 224;
    localparam int STEP  = 8;
    localparam int OUT_W = SRC_W / STEP;
    localparam int OUT_H = SRC_H / STEP;
    localparam int DEPTH = OUT_W * OUT_H;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_PRIME   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    function automatic logic on_grid(input int col, input int row, input int step);
        return ((col % step) == 0) && ((row % step) == 0);
    endfunction

endpackage

// File: rtl/cam_pixel_ram.sv
// Decimated image store: one write port, one registered read port with enable.
// Only the read register is reset; the array itself is never cleared.
module cam_pixel_ram #(
    parameter int DEPTH = cam_pkg::DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= 8'h00;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cam_frame_buffer.sv
// Camera frame grabber: decimates a raw pixel stream into an OUT_W x OUT_H buffer
// and hands it to the CPU one pixel per read strobe, show-ahead on pixel_o.
//   state   | meaning
//   IDLE    | nothing captured since reset
//   ARMED   | waiting for start-of-frame pixel
//   CAPTURE | decimating and writing the frame
//   PRIME   | fetching mem[0] into the output register
//   DONE    | image complete, pops allowed
module cam_frame_buffer #(
    parameter int SRC_W = cam_pkg::SRC_W,
    parameter int SRC_H = cam_pkg::SRC_H,
    parameter int STEP  = cam_pkg::STEP
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       capture_i,
    input  logic       read_valid_i,
    output logic [7:0] pixel_o,
    input  logic       pix_valid_i,
    input  logic       pix_sof_i,
    input  logic [7:0] pix_data_i,
    output logic       busy_o,
    output logic       done_o
);
    import cam_pkg::*;

    localparam int OUT_W = SRC_W / STEP;
    localparam int OUT_H = SRC_H / STEP;
    localparam int DEPTH = OUT_W * OUT_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(SRC_W);
    localparam int RW    = $clog2(SRC_H);

    localparam logic [CW-1:0] COL_LAST = CW'(SRC_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SRC_H - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, wr_cur;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic [AW-1:0] rd_addr;
    logic          pix_take, keep, frame_end, wr_en, rd_en;

    // A start-of-frame pixel always restarts the raster at (0,0), in ARMED or CAPTURE.
    assign col_cur    = pix_sof_i ? '0 : col_q;
    assign row_cur    = pix_sof_i ? '0 : row_q;
    assign wr_cur     = pix_sof_i ? '0 : wr_ptr_q;
    assign keep       = on_grid(int'(col_cur), int'(row_cur), STEP);
    assign frame_end  = (col_cur == COL_LAST) && (row_cur == ROW_LAST);
    assign rd_ptr_inc = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

    always_comb begin
        pix_take = 1'b0;
        if (state_q == ST_ARMED) begin
            pix_take = pix_valid_i & pix_sof_i;
        end else if (state_q == ST_CAPTURE) begin
            pix_take = pix_valid_i;
        end
    end

    assign wr_en = pix_take & keep;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rd_en    = 1'b0;
        rd_addr  = rd_ptr_inc;
        case (state_q)
            ST_IDLE: begin
                if (capture_i) begin
                    state_d  = ST_ARMED;
                    col_d    = '0;
                    row_d    = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            ST_ARMED, ST_CAPTURE: begin
                if (pix_take) begin
                    if (col_cur == COL_LAST) begin
                        col_d = '0;
                        row_d = row_cur + 1'b1;
                    end else begin
                        col_d = col_cur + 1'b1;
                        row_d = row_cur;
                    end
                    // Hold at the last slot so the pointer never leaves the buffer.
                    if (wr_en && (wr_cur != PTR_LAST)) begin
                        wr_ptr_d = wr_cur + 1'b1;
                    end else begin
                        wr_ptr_d = wr_cur;
                    end
                    state_d = frame_end ? ST_PRIME : ST_CAPTURE;
                end
            end
            ST_PRIME: begin
                rd_en   = 1'b1;
                rd_addr = '0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (capture_i) begin
                    state_d  = ST_ARMED;
                    col_d    = '0;
                    row_d    = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else if (read_valid_i) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    cam_pixel_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_cur),
        .wr_data_i(pix_data_i),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_addr),
        .rd_data_o(pixel_o)
    );

    assign busy_o = (state_q == ST_ARMED) || (state_q == ST_CAPTURE) || (state_q == ST_PRIME);
    assign done_o = (state_q == ST_DONE);

endmodule
